add_sub_bist: RTL and testbench

Built-in self-test sequencer for the `add_sub` sign-magnitude adder/subtractor. It drives the DUT operand side and sweeps all 128 `{selection, num1, num2}` combinations. It compares `result`/`zeroflag` against an internal golden model and reports pass/fail counts. It sits next to `add_sub` as the on-chip replacement for the simulation bench and connects port-for-port to it.

---
 rtl/add_sub_bist.sv | 144 ++++++++++++++
 tb/tb_add_sub_bist.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/add_sub_bist.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_bist
// Description : Built-in self-test sequencer for the add_sub sign-magnitude
//               adder/subtractor. Sweeps all 128 {selection,num1,num2}
//               vectors, compares result/zeroflag against a golden model and
//               counts passes and failures.
//               Optional first-failure capture: ADD_SUB_BIST_FAIL_CAPTURE_EN
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_bist #(
  parameter int SETTLE = 1            // DUT settle cycles per vector, 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] num1,
  output logic [2:0] num2,
  output logic       selection,
  input  logic [4:0] result,
  input  logic       zeroflag,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_count,
  output logic [7:0] fail_count,
  output logic [6:0] fail_vector,
  output logic [5:0] fail_result
);

  localparam logic [3:0] c_settle   = 4'(SETTLE);
  localparam logic [6:0] c_last_idx = 7'd127;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_idx;
  logic [3:0] r_settle;
  logic [7:0] r_pass;
  logic [7:0] r_fail;

  logic       w_start_ok;
  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_v;
  logic [3:0] w_mag;
  logic [4:0] w_exp_result;
  logic       w_exp_zf;
  logic       w_match;

  // Start is only honoured when no sweep is in flight.
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Golden model: sign-magnitude operands to 4-bit two's complement, then
  // back to sign-magnitude; a zero result always carries sign 0.
  assign w_a          = r_idx[5] ? (4'd0 - {2'b00, r_idx[4:3]}) : {2'b00, r_idx[4:3]};
  assign w_b          = r_idx[2] ? (4'd0 - {2'b00, r_idx[1:0]}) : {2'b00, r_idx[1:0]};
  assign w_v          = r_idx[6] ? (w_a - w_b) : (w_a + w_b);
  assign w_mag        = w_v[3] ? (4'd0 - w_v) : w_v;
  assign w_exp_result = {w_v[3], w_mag};
  assign w_exp_zf     = (w_mag == 4'd0);
  assign w_match      = (result == w_exp_result) && (zeroflag == w_exp_zf);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: APPLY lasts SETTLE cycles, CHECK one cycle per vector.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_APPLY;
      S_APPLY:        if (r_settle == 4'd1) w_state_nxt = S_CHECK;
      S_CHECK:        w_state_nxt = (r_idx == c_last_idx) ? S_DONE : S_APPLY;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Vector index, settle counter and pass/fail counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= 7'd0;
      r_settle <= 4'd0;
      r_pass   <= 8'd0;
      r_fail   <= 8'd0;
    end else if (w_start_ok) begin
      r_idx    <= 7'd0;
      r_settle <= c_settle;
      r_pass   <= 8'd0;
      r_fail   <= 8'd0;
    end else if (r_state == S_APPLY) begin
      r_settle <= r_settle - 4'd1;
    end else if (r_state == S_CHECK) begin
      if (w_match) r_pass <= r_pass + 8'd1;
      else         r_fail <= r_fail + 8'd1;
      if (r_idx != c_last_idx) begin
        r_idx    <= r_idx + 7'd1;
        r_settle <= c_settle;
      end
    end
  end

  assign selection  = r_idx[6];
  assign num1       = r_idx[5:3];
  assign num2       = r_idx[2:0];
  assign busy       = (r_state == S_APPLY) || (r_state == S_CHECK);
  assign done       = (r_state == S_DONE);
  assign pass_count = r_pass;
  assign fail_count = r_fail;

`ifdef ADD_SUB_BIST_FAIL_CAPTURE_EN
  logic       r_captured;
  logic [6:0] r_fail_vector;
  logic [5:0] r_fail_result;

  // Capture the first mismatching vector and its observed response.
  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_captured    <= 1'b0;
      r_fail_vector <= 7'd0;
      r_fail_result <= 6'd0;
    end else if ((r_state == S_CHECK) && !w_match && !r_captured) begin
      r_captured    <= 1'b1;
      r_fail_vector <= r_idx;
      r_fail_result <= {zeroflag, result};
    end
  end

  assign fail_vector = r_fail_vector;
  assign fail_result = r_fail_result;
`else
  assign fail_vector = 7'd0;
  assign fail_result = 6'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_sub_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_sub_bist
// Description : Directed bench for add_sub_bist. Two instances (SETTLE=1 and
//               SETTLE=3) each drive a behavioural add_sub with selectable
//               faults: 0 = correct, 1 = zeroflag stuck 0, 2 = zero as 10000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_sub_bist;

  logic       clk;
  logic       reset;
  logic       start1, start3;
  int         mode1, mode3;
  int         n_checks, n_errors;

  logic [2:0] n1a, n2a, n1b, n2b;
  logic       sel1, sel3;
  logic [4:0] res1, res3;
  logic       zf1, zf3;
  logic       busy1, busy3, done1, done3;
  logic [7:0] pass1, fail1, pass3, fail3;
  logic [6:0] fv1, fv3;
  logic [5:0] fr1, fr3;

  // Behavioural add_sub with optional faults, returns {zeroflag,result}.
  function automatic logic [5:0] dut_model(input logic sel, input logic [2:0] a,
                                           input logic [2:0] b, input int mode);
    int va, vb, v;
    logic [4:0] r;
    logic z;
    va = a[2] ? -int'(a[1:0]) : int'(a[1:0]);
    vb = b[2] ? -int'(b[1:0]) : int'(b[1:0]);
    v  = sel ? (va - vb) : (va + vb);
    r  = {(v < 0), 4'((v < 0) ? -v : v)};
    z  = (v == 0);
    if (mode == 1) z = 1'b0;
    if (mode == 2 && v == 0) r = 5'b10000;
    return {z, r};
  endfunction

  assign {zf1, res1} = dut_model(sel1, n1a, n2a, mode1);
  assign {zf3, res3} = dut_model(sel3, n1b, n2b, mode3);

  add_sub_bist #(.SETTLE(1)) u_bist1 (
    .clk(clk), .reset(reset), .start(start1),
    .num1(n1a), .num2(n2a), .selection(sel1),
    .result(res1), .zeroflag(zf1),
    .busy(busy1), .done(done1),
    .pass_count(pass1), .fail_count(fail1),
    .fail_vector(fv1), .fail_result(fr1)
  );

  add_sub_bist #(.SETTLE(3)) u_bist3 (
    .clk(clk), .reset(reset), .start(start3),
    .num1(n1b), .num2(n2b), .selection(sel3),
    .result(res3), .zeroflag(zf3),
    .busy(busy3), .done(done3),
    .pass_count(pass3), .fail_count(fail3),
    .fail_vector(fv3), .fail_result(fr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then count negedges until done; optionally pulse start
  // again at n=2 (APPLY) and n=4 (CHECK), which must be ignored.
  task automatic run_sweep(input int which, input bit glitch, output int lat);
    int n;
    n   = 0;
    lat = -1;
    @(negedge clk);
    if (which == 1) start1 = 1'b1; else start3 = 1'b1;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      start1 = 1'b0;
      start3 = 1'b0;
      if (n == 1) check_val("busy_after_start", (which == 1) ? busy1 : busy3, 1);
      if (glitch && (n == 2 || n == 4)) begin
        if (which == 1) start1 = 1'b1; else start3 = 1'b1;
      end
      if ((which == 1) ? done1 : done3) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [5:0] exp_fr;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start1   = 1'b0;
    start3   = 1'b0;
    mode1    = 0;
    mode3    = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state of both instances.
    check_val("rst_outs1", {n1a, n2a, sel1, busy1, done1, pass1, fail1, fv1, fr1}, 0);
    check_val("rst_outs3", {n1b, n2b, sel3, busy3, done3, pass3, fail3, fv3, fr3}, 0);

    // Golden DUT, SETTLE=1.
    run_sweep(1, 1'b0, lat);
    check_val("gold_latency", lat, 257);
    check_val("gold_pass", pass1, 128);
    check_val("gold_fail", fail1, 0);
    check_val("gold_busy_low", busy1, 0);
    check_val("gold_capture", {fv1, fr1}, 0);

    // zeroflag stuck at 0; also a restart from DONE.
    mode1 = 1;
    run_sweep(1, 1'b0, lat);
    check_val("zf0_latency", lat, 257);
    check_val("zf0_pass", pass1, 108);
    check_val("zf0_fail", fail1, 20);
    check_val("zf0_fvec", fv1, 7'b0000000);
    check_val("zf0_fres", fr1, 6'b000000);

    // Negative zero emitted for every zero result.
    mode1 = 2;
    run_sweep(1, 1'b0, lat);
    check_val("nz_pass", pass1, 108);
    check_val("nz_fail", fail1, 20);
    check_val("nz_fvec", fv1, 7'b0000000);
`ifdef ADD_SUB_BIST_FAIL_CAPTURE_EN
    exp_fr = 6'b110000;
`else
    exp_fr = 6'b000000;
`endif
    check_val("nz_fres", fr1, exp_fr);

    // Reset 50 cycles into a sweep.
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (49) @(negedge clk);
    check_val("mid_busy", busy1, 1);
    check_val("mid_ops_nonzero", ({n1a, n2a, sel1} != 7'd0), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("midrst_outs", {n1a, n2a, sel1, busy1, done1, pass1, fail1, fv1, fr1}, 0);
    @(negedge clk);
    check_val("midrst_stays_idle", {busy1, done1}, 0);
    run_sweep(1, 1'b0, lat);
    check_val("post_rst_latency", lat, 257);
    check_val("post_rst_pass", pass3 == 8'd0 ? pass1 : 8'hFF, 128);
    check_val("post_rst_fail", fail1, 0);

    // SETTLE=3 with start pulses during APPLY and CHECK.
    mode3 = 1;
    run_sweep(3, 1'b1, lat);
    check_val("s3_latency", lat, 513);
    check_val("s3_pass", pass3, 108);
    check_val("s3_fail", fail3, 20);

    // Start in DONE clears counts on the next edge, then a repeat sweep.
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check_val("s3_restart_counts", {pass3, fail3}, 0);
    check_val("s3_restart_state", {busy3, done3}, 2'b10);
    lat = -1;
    for (int n = 1; n < 3000; n++) begin
      @(negedge clk);
      if (done3) begin
        lat = n + 1;
        break;
      end
    end
    check_val("s3_rerun_latency", lat, 513);
    check_val("s3_rerun_pass", pass3, 108);
    check_val("s3_rerun_fail", fail3, 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
